// File: rtl/controller_pkg.sv
// Shared types and encodings for the multicycle controller: states, opcodes,
// instruction classes and control-field encodings.
package controller_pkg;

   localparam int unsigned OP_W  = 7;
   localparam int unsigned CNT_W = 8;

   localparam logic [OP_W-1:0] OP_R_TYPE = 7'b0110011;
   localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BR     = 7'b1100011;
   localparam logic [OP_W-1:0] OP_I_TYPE = 7'b0010011;
   localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] ALUSRC_REG  = 2'b00;
   localparam logic [1:0] ALUSRC_IMM  = 2'b01;
   localparam logic [1:0] ALUSRC_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_IDLE_ERR
   } state_e;

   typedef enum logic [3:0] {
      CL_NONE, CL_R, CL_I, CL_LW, CL_SW, CL_BR, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR
   } op_class_e;

   typedef struct packed {
      logic       mem_req;
      logic       pc_write;
      logic       ir_write;
      logic [1:0] alu_src;
      logic [1:0] alu_op;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
   } ctrl_t;

   function automatic logic is_jump_class(input op_class_e c);
      return (c == CL_JAL) || (c == CL_JALR);
   endfunction

endpackage

// File: rtl/multicycle_controller_classifier.sv
// Maps a raw opcode to its instruction class; jump/upper-immediate forms are
// only recognised when EN_JUMP is set.
module opcode_classifier
   import controller_pkg::*;
#(
   parameter bit EN_JUMP = 1'b1
) (
   input  logic [OP_W-1:0] opcode_i,
   output op_class_e       class_o,
   output logic            legal_o
);

   always_comb begin
      class_o = CL_NONE;
      case (opcode_i)
         OP_R_TYPE: class_o = CL_R;
         OP_I_TYPE: class_o = CL_I;
         OP_LW:     class_o = CL_LW;
         OP_SW:     class_o = CL_SW;
         OP_BR:     class_o = CL_BR;
         OP_LUI:    class_o = EN_JUMP ? CL_LUI   : CL_NONE;
         OP_AUIPC:  class_o = EN_JUMP ? CL_AUIPC : CL_NONE;
         OP_JAL:    class_o = EN_JUMP ? CL_JAL   : CL_NONE;
         OP_JALR:   class_o = EN_JUMP ? CL_JALR  : CL_NONE;
         default:   class_o = CL_NONE;
      endcase
      legal_o = (class_o != CL_NONE);
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory wait timeout and sticky illegal-instruction / memory-fault flags.
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter bit          EN_JUMP     = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] Opcode,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            pc_write,
   output logic            ir_write,
   output logic [1:0]      ALUSrc,
   output logic [1:0]      ALUOp,
   output logic [1:0]      MemtoReg,
   output logic            RegWrite,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            Branch,
   output logic            Jump,
   output logic            illegal_instr,
   output logic            mem_fault,
   output logic            busy
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ill_q, ill_d;
   logic             flt_q, flt_d;
   ctrl_t            ctrl_c;
   ctrl_t            ctrl_gated_c;
   logic [OP_W-1:0]  cls_op_c;
   op_class_e        cls_c;
   logic             legal_c;
   logic             wait_expire_c;

   // DECODE judges the incoming opcode; every later state decodes the latched one
   assign cls_op_c = (state_q == S_DECODE) ? Opcode : op_q;

   opcode_classifier #(.EN_JUMP(EN_JUMP)) u_classifier (
      .opcode_i (cls_op_c),
      .class_o  (cls_c),
      .legal_o  (legal_c)
   );

   // A ready in the last allowed wait cycle wins over the timeout
   assign wait_expire_c = !mem_ready && (cnt_q == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         flt_q   <= flt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      ill_d   = ill_q;
      flt_d   = flt_q;
      ctrl_c  = '0;
      case (state_q)
         S_FETCH: begin
            ctrl_c.mem_req  = 1'b1;
            ctrl_c.mem_read = 1'b1;
            ctrl_c.alu_src  = ALUSRC_FOUR;
            ctrl_c.alu_op   = ALUOP_ADD;
            if (mem_ready) begin
               ctrl_c.ir_write = 1'b1;
               ctrl_c.pc_write = 1'b1;
               cnt_d           = '0;
               state_d         = S_DECODE;
            end else if (wait_expire_c) begin
               flt_d   = 1'b1;
               state_d = S_IDLE_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            op_d = Opcode;
            if (legal_c) begin
               state_d = S_EXEC;
            end else begin
               ill_d   = 1'b1;
               state_d = S_IDLE_ERR;
            end
         end
         S_EXEC: begin
            cnt_d   = '0;
            state_d = S_WB;
            case (cls_c)
               CL_R: begin
                  ctrl_c.alu_src = ALUSRC_REG;
                  ctrl_c.alu_op  = ALUOP_R;
               end
               CL_I: begin
                  ctrl_c.alu_src = ALUSRC_IMM;
                  ctrl_c.alu_op  = ALUOP_I;
               end
               CL_BR: begin
                  ctrl_c.alu_src = ALUSRC_REG;
                  ctrl_c.alu_op  = ALUOP_BR;
                  ctrl_c.branch  = 1'b1;
                  state_d        = S_FETCH;
               end
               CL_LW, CL_SW: begin
                  ctrl_c.alu_src = ALUSRC_IMM;
                  ctrl_c.alu_op  = ALUOP_ADD;
                  state_d        = S_MEM;
               end
               default: begin
                  ctrl_c.alu_src = ALUSRC_IMM;
                  ctrl_c.alu_op  = ALUOP_ADD;
               end
            endcase
         end
         S_MEM: begin
            ctrl_c.mem_req   = 1'b1;
            ctrl_c.mem_read  = (cls_c == CL_LW);
            ctrl_c.mem_write = (cls_c == CL_SW);
            if (mem_ready) begin
               cnt_d   = '0;
               state_d = (cls_c == CL_LW) ? S_WB : S_FETCH;
            end else if (wait_expire_c) begin
               flt_d   = 1'b1;
               state_d = S_IDLE_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            ctrl_c.reg_write = 1'b1;
            if (cls_c == CL_LW) begin
               ctrl_c.mem_to_reg = WB_MEM;
            end else if (is_jump_class(cls_c)) begin
               ctrl_c.mem_to_reg = WB_PC4;
               ctrl_c.jump       = 1'b1;
               ctrl_c.pc_write   = 1'b1;
            end else begin
               ctrl_c.mem_to_reg = WB_ALU;
            end
            cnt_d   = '0;
            state_d = S_FETCH;
         end
         S_IDLE_ERR: state_d = S_IDLE_ERR;
         default:    state_d = S_IDLE_ERR;
      endcase
   end

   // Strobes are forced low for as long as reset is asserted
   assign ctrl_gated_c = rst_n ? ctrl_c : '0;

   assign mem_req       = ctrl_gated_c.mem_req;
   assign pc_write      = ctrl_gated_c.pc_write;
   assign ir_write      = ctrl_gated_c.ir_write;
   assign ALUSrc        = ctrl_gated_c.alu_src;
   assign ALUOp         = ctrl_gated_c.alu_op;
   assign MemtoReg      = ctrl_gated_c.mem_to_reg;
   assign RegWrite      = ctrl_gated_c.reg_write;
   assign MemRead       = ctrl_gated_c.mem_read;
   assign MemWrite      = ctrl_gated_c.mem_write;
   assign Branch        = ctrl_gated_c.branch;
   assign Jump          = ctrl_gated_c.jump;
   assign illegal_instr = ill_q;
   assign mem_fault     = flt_q;
   assign busy          = (state_q != S_IDLE_ERR);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: an instruction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_multicycle_controller;

   localparam int unsigned TO = 4;

   localparam logic [6:0] R_OP   = 7'b0110011;
   localparam logic [6:0] I_OP   = 7'b0010011;
   localparam logic [6:0] LW_OP  = 7'b0000011;
   localparam logic [6:0] SW_OP  = 7'b0100011;
   localparam logic [6:0] BR_OP  = 7'b1100011;
   localparam logic [6:0] LUI_OP = 7'b0110111;
   localparam logic [6:0] AUI_OP = 7'b0010111;
   localparam logic [6:0] JAL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP  = 7'b1100111;
   localparam logic [6:0] OPS [9] = '{R_OP, I_OP, LW_OP, SW_OP, BR_OP,
                                       LUI_OP, AUI_OP, JAL_OP, JR_OP};

   // model phases: position within one instruction's life
   localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PX = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       mem_ready = 1'b0;
   logic [6:0] Opcode = 7'd0;

   logic       mem_req, pc_write, ir_write, RegWrite, MemRead, MemWrite;
   logic       Branch, Jump, illegal_instr, mem_fault, busy;
   logic [1:0] ALUSrc, ALUOp, MemtoReg;

   logic       nj_mem_req, nj_pc_write, nj_ir_write, nj_RegWrite, nj_MemRead;
   logic       nj_MemWrite, nj_Branch, nj_Jump, nj_illegal, nj_fault, nj_busy;
   logic [1:0] nj_ALUSrc, nj_ALUOp, nj_MemtoReg;

   int  n_chk = 0;
   int  n_pass = 0;
   bit  active = 1'b0;

   int         ph = PF;
   int         w = 0;
   logic [6:0] mop = 7'd0;
   bit         m_ill = 1'b0;
   bit         m_flt = 1'b0;

   multicycle_controller #(.MEM_TIMEOUT(TO), .EN_JUMP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .pc_write(pc_write), .ir_write(ir_write),
      .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .Branch(Branch), .Jump(Jump), .illegal_instr(illegal_instr),
      .mem_fault(mem_fault), .busy(busy)
   );

   multicycle_controller #(.EN_JUMP(1'b0)) dut_nj (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
      .mem_req(nj_mem_req), .pc_write(nj_pc_write), .ir_write(nj_ir_write),
      .ALUSrc(nj_ALUSrc), .ALUOp(nj_ALUOp), .MemtoReg(nj_MemtoReg),
      .RegWrite(nj_RegWrite), .MemRead(nj_MemRead), .MemWrite(nj_MemWrite),
      .Branch(nj_Branch), .Jump(nj_Jump), .illegal_instr(nj_illegal),
      .mem_fault(nj_fault), .busy(nj_busy)
   );

   always #5 clk = ~clk;

   function automatic bit legal(input logic [6:0] op);
      return (op == R_OP) || (op == I_OP) || (op == LW_OP) || (op == SW_OP) ||
             (op == BR_OP) || (op == LUI_OP) || (op == AUI_OP) ||
             (op == JAL_OP) || (op == JR_OP);
   endfunction

   // expected {mem_req,pc_write,ir_write,ALUSrc,ALUOp,MemtoReg,RegWrite,
   //           MemRead,MemWrite,Branch,Jump,illegal,fault,busy}
   function automatic logic [16:0] expect_vec(input int p, input logic [6:0] op,
                                              input logic rdy, input bit il, input bit fl);
      logic mr = 0, pw = 0, iw = 0, rw = 0, rd = 0, wr = 0, br = 0, jp = 0;
      logic [1:0] as = 0, ao = 0, mt = 0;
      bit is_j = (op == JAL_OP) || (op == JR_OP);
      if (p == PF) begin
         mr = 1; rd = 1; as = 2'd2; iw = rdy; pw = rdy;
      end else if (p == PE) begin
         if (op == R_OP) ao = 2'd2;
         else if (op == I_OP) begin as = 2'd1; ao = 2'd3; end
         else if (op == BR_OP) begin ao = 2'd1; br = 1; end
         else as = 2'd1;
      end else if (p == PM) begin
         mr = 1; rd = (op == LW_OP); wr = (op == SW_OP);
      end else if (p == PW) begin
         rw = 1;
         mt = (op == LW_OP) ? 2'd1 : (is_j ? 2'd2 : 2'd0);
         jp = is_j; pw = is_j;
      end
      return {mr, pw, iw, as, ao, mt, rw, rd, wr, br, jp, il, fl, (p != PX)};
   endfunction

   // model advance on each rising edge
   always @(posedge clk) begin
      if (active) begin
         if (!rst_n) begin
            ph = PF; w = 0; mop = 7'd0; m_ill = 0; m_flt = 0;
         end else begin
            case (ph)
               PF, PM: begin
                  if (mem_ready) begin
                     w = 0;
                     if (ph == PF) ph = PD;
                     else ph = (mop == LW_OP) ? PW : PF;
                  end else if (w + 1 >= TO) begin
                     m_flt = 1; ph = PX;
                  end else begin
                     w = w + 1;
                  end
               end
               PD: begin
                  mop = Opcode;
                  if (legal(Opcode)) ph = PE;
                  else begin m_ill = 1; ph = PX; end
               end
               PE: begin
                  w = 0;
                  if (mop == BR_OP) ph = PF;
                  else if (mop == LW_OP || mop == SW_OP) ph = PM;
                  else ph = PW;
               end
               PW: begin w = 0; ph = PF; end
               default: ph = PX;
            endcase
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      logic [16:0] got, exp;
      if (active) begin
         got = {mem_req, pc_write, ir_write, ALUSrc, ALUOp, MemtoReg, RegWrite,
                MemRead, MemWrite, Branch, Jump, illegal_instr, mem_fault, busy};
         exp = rst_n ? expect_vec(ph, mop, mem_ready, m_ill, m_flt) : 17'h00001;
         n_chk++;
         if (got === exp) n_pass++;
         else $display("FAIL model t=%0t phase=%0d op=%b got=%h exp=%h",
                       $time, ph, mop, got, exp);
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
   endtask

   task automatic step(input logic r, input logic rdy, input logic [6:0] op);
      @(posedge clk);
      #1;
      rst_n = r; mem_ready = rdy; Opcode = op;
      @(negedge clk);
   endtask

   initial begin
      int err_cyc;
      logic r, rdy;
      logic [6:0] op;

      #1 rst_n = 1'b0;
      active = 1'b1;

      // zero-wait add
      step(0, 0, R_OP);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_flags", {illegal_instr, mem_fault}, 0);
      step(1, 1, R_OP); chk("add_c1_ir_write", ir_write, 1);
      chk("add_c1_mem_req", mem_req, 1);
      step(1, 0, R_OP); chk("add_c2_mem_req", mem_req, 0);
      step(1, 0, R_OP); chk("add_c3_aluop", ALUOp, 2);
      chk("add_nj_legal", nj_illegal, 0);
      step(1, 0, R_OP); chk("add_c4_regwrite", RegWrite, 1);
      chk("add_c4_memtoreg", MemtoReg, 0);
      step(1, 0, R_OP); chk("add_c5_regwrite", RegWrite, 0);
      chk("add_c5_fetch", mem_req, 1);

      // LW with three wait cycles in MEM
      step(0, 0, LW_OP);
      step(1, 1, LW_OP);
      step(1, 0, LW_OP);
      step(1, 0, LW_OP);
      step(1, 0, LW_OP);
      step(1, 0, LW_OP);
      step(1, 0, LW_OP); chk("lw_c6_memread", MemRead, 1);
      step(1, 1, LW_OP);
      step(1, 0, LW_OP); chk("lw_c8_regwrite", RegWrite, 1);
      chk("lw_c8_memtoreg", MemtoReg, 1);
      chk("lw_c8_fault", mem_fault, 0);

      // fetch timeout
      step(0, 0, R_OP);
      for (int i = 0; i < 4; i++) step(1, 0, R_OP);
      chk("to_c4_fault", mem_fault, 0);
      chk("to_c4_busy", busy, 1);
      step(1, 0, R_OP); chk("to_c5_fault", mem_fault, 1);
      chk("to_c5_busy", busy, 0);
      chk("to_c5_strobes", {mem_req, ir_write, pc_write, RegWrite}, 0);

      // ready coincident with the last wait cycle
      step(0, 0, R_OP);
      for (int i = 0; i < 3; i++) step(1, 0, R_OP);
      step(1, 1, R_OP); chk("coin_c4_ir_write", ir_write, 1);
      step(1, 0, R_OP); chk("coin_c5_fault", mem_fault, 0);
      chk("coin_c5_busy", busy, 1);

      // illegal opcode
      step(0, 0, 7'h7f);
      step(1, 1, 7'h7f);
      step(1, 0, 7'h7f);
      step(1, 0, 7'h7f); chk("ill_c3_flag", illegal_instr, 1);
      chk("ill_c3_busy", busy, 0);

      // JAL: legal on the main instance, illegal with jumps disabled
      step(0, 0, JAL_OP);
      step(1, 1, JAL_OP);
      step(1, 0, JAL_OP);
      step(1, 0, JAL_OP); chk("jal_nj_illegal", nj_illegal, 1);
      chk("jal_nj_busy", nj_busy, 0);
      chk("jal_main_legal", illegal_instr, 0);
      step(1, 0, JAL_OP); chk("jal_c4_jump_pcw", {Jump, pc_write}, 3);
      chk("jal_c4_memtoreg", MemtoReg, 2);

      // reset during SW memory wait
      step(0, 0, SW_OP);
      step(1, 1, SW_OP);
      step(1, 0, SW_OP);
      step(1, 0, SW_OP);
      step(1, 0, SW_OP); chk("sw_c4_memwrite", MemWrite, 1);
      step(0, 0, SW_OP); chk("sw_rst_memwrite", MemWrite, 0);
      chk("sw_rst_mem_req", mem_req, 0);
      step(1, 0, SW_OP); chk("sw_post_mem_req", mem_req, 1);
      chk("sw_post_rw", {MemRead, MemWrite}, 2);

      // randomised traffic
      err_cyc = 0;
      for (int i = 0; i < 4000; i++) begin
         r = 1'b1;
         if (ph == PX) err_cyc++;
         if (err_cyc > 3 || $urandom_range(0, 299) == 0) begin
            r = 1'b0; err_cyc = 0;
         end
         if ($urandom_range(0, 9) < 8) op = OPS[$urandom_range(0, 8)];
         else op = 7'($urandom);
         rdy = ($urandom_range(0, 99) < 55);
         step(r, rdy, op);
      end

      active = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles one memory wait may last before fault (legal range 2..255).
REQ-002 Parameter EN_JUMP, default 1, enables JAL/JALR/LUI/AUIPC decode; when 0 they are illegal.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Opcode  in  7  instruction opcode field, valid from the cycle after ir_write.
REQ-006 mem_ready  in  1  memory completes current request this cycle.
REQ-007 mem_req  out  1  memory request active (FETCH or MEM state).
REQ-008 pc_write, ir_write  out  1 each  PC update / instruction register load strobes.
REQ-009 ALUSrc  out  2  00 reg2, 01 immediate, 10 constant 4.
REQ-010 ALUOp  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type ALU.
REQ-011 MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4.
REQ-012 RegWrite, MemRead, MemWrite, Branch, Jump  out  1 each  same meanings as the single-cycle controller.
REQ-013 illegal_instr, mem_fault  out  1 each  sticky error flags.
REQ-014 busy  out  1  high in every state except IDLE_ERR.

Function
REQ-015 States SHALL be FETCH, DECODE, EXEC, MEM, WB, IDLE_ERR; all outputs Moore-decoded from state and latched opcode op_q.
REQ-016 FETCH: mem_req=1, MemRead=1; on mem_ready, ir_write=1 and pc_write=1 (PC+4), go DECODE; else stay.
REQ-017 DECODE: op_q <= Opcode; recognised opcodes go EXEC; any other (incl. jump-class with EN_JUMP=0) sets illegal_instr, goes IDLE_ERR.
REQ-018 EXEC: drives ALUSrc/ALUOp per class; BEQ asserts Branch and returns to FETCH; LW/SW go MEM; R-type, SRAI/I-type, LUI, AUIPC, JAL, JALR go WB.
REQ-019 MEM: mem_req=1, MemRead=1 (LW) or MemWrite=1 (SW); wait for mem_ready; LW then WB, SW then FETCH.
REQ-020 WB: RegWrite=1 for exactly one cycle, MemtoReg 01 for LW, 10 for JAL/JALR, 00 otherwise; JAL/JALR assert Jump and pc_write; then FETCH.
REQ-021 Zero-wait latency (mem_ready high on entry): BEQ 3 cycles, R/I/U-type 4, SW 4, JAL/JALR 4, LW 5.
REQ-022 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle mem_ready is low; reaching MEM_TIMEOUT with mem_ready still low sets mem_fault, goes IDLE_ERR.
REQ-023 mem_ready arriving in the same cycle the counter would reach MEM_TIMEOUT SHALL win (no fault).
REQ-024 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-025 IDLE_ERR: all strobes 0, busy=0, flags held; exit only via reset.
REQ-026 RegWrite, MemWrite, pc_write SHALL never be high in the same cycle as mem_fault or illegal_instr transition.

Reset
REQ-027 rst_n low SHALL force FETCH, op_q=0, counter=0, flags=0, all strobes 0 asynchronously, including mid-MEM wait.
REQ-028 First mem_req SHALL appear the first cycle after rst_n deasserts.

Structure
REQ-029 Package controller_pkg holds state enum, opcode constants (R_TYPE, LW, SW, BR, SRAI/I-type, LUI, AUIPC, JAL, JALR), ALUSrc/ALUOp/MemtoReg encodings.
REQ-030 Combinational sub-module opcode_classifier maps opcode and EN_JUMP to class and legal bit; FSM, counter and output decode stay in the top.

Verification
REQ-031 Zero-wait add (0110011) -> RegWrite high only in cycle 4, MemtoReg=00, back to FETCH cycle 5.
REQ-032 LW with mem_ready delayed 3 cycles in MEM -> WB at cycle 8, MemtoReg=01, no fault.
REQ-033 MEM_TIMEOUT=4, mem_ready never high in FETCH -> mem_fault=1 after 4 wait cycles, busy=0, no strobes.
REQ-034 Opcode 7'b1111111 -> illegal_instr=1 leaving DECODE; EN_JUMP=0 with JAL (1101111) -> same.
REQ-035 rst_n pulsed low during SW MEM wait -> MemWrite drops immediately, FETCH with mem_req on first post-reset cycle.
REQ-036 mem_ready coincident with timeout cycle -> normal progress, mem_fault stays 0.
